spart_key_rx: RTL and testbench

UART receiver and key decoder that sits directly upstream of the CPU's SPART input. It deserialises 8N1 frames from the host serial line and maps each received ASCII character to a one-hot 13-bit key vector. It presents each valid key to the CPU as SPART_keys, qualified by a single-cycle SPART_we strobe. Unmapped characters are dropped; framing errors are flagged and never reach the CPU.

---
 rtl/spart_key_rx.sv | 166 ++++++++++++++++
 tb/tb_spart_key_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spart_key_rx.sv
// spart_key_rx: 8N1 UART receiver feeding the CPU's SPART key input.
// Each correctly framed byte updates rx_data. Mapped characters become a
// one-hot 13-bit key vector qualified by SPART_we. ESC produces an all-zero
// vector (release). A stop bit sampled low raises rx_err and parks the
// receiver until the line returns high.
module spart_key_rx #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  output logic        SPART_we,
  output logic [12:0] SPART_keys,
  output logic [7:0]  rx_data,
  output logic        rx_err,
  output logic        rx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t          state;
  logic            rxd_m;
  logic            rxd_s;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;

  logic [7:0]      folded;
  logic            dec_hit;
  logic [12:0]     dec_keys;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  // Character decode of the completed shift register (uppercase folds to lowercase)
  always_comb begin
    folded = shift;
    if (shift >= 8'h41 && shift <= 8'h5A) begin
      folded = shift | 8'h20;
    end
    dec_hit  = 1'b1;
    dec_keys = 13'h0000;
    case (folded)
      8'h77:   dec_keys = 13'h0001;  // w
      8'h73:   dec_keys = 13'h0002;  // s
      8'h61:   dec_keys = 13'h0004;  // a
      8'h64:   dec_keys = 13'h0008;  // d
      8'h71:   dec_keys = 13'h0010;  // q
      8'h65:   dec_keys = 13'h0020;  // e
      8'h69:   dec_keys = 13'h0040;  // i
      8'h6B:   dec_keys = 13'h0080;  // k
      8'h6A:   dec_keys = 13'h0100;  // j
      8'h6C:   dec_keys = 13'h0200;  // l
      8'h75:   dec_keys = 13'h0400;  // u
      8'h6F:   dec_keys = 13'h0800;  // o
      8'h20:   dec_keys = 13'h1000;  // space
      8'h1B:   dec_keys = 13'h0000;  // ESC: release all keys
      default: dec_hit  = 1'b0;
    endcase
  end

  // Receive FSM with registered strobes; SPART_we/rx_err are one-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      SPART_we   <= 1'b0;
      SPART_keys <= 13'h0000;
      rx_data    <= 8'h00;
      rx_err     <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      SPART_we <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rxd_s) begin
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              // Start bit gone by mid-bit: treat as a glitch
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            shift    <= {rxd_s, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            if (rxd_s) begin
              rx_data <= shift;
              if (dec_hit) begin
                SPART_we   <= 1'b1;
                SPART_keys <= dec_keys;
              end
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              rx_err <= 1'b1;
              state  <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        BREAK: begin
          // Hold off until the line is released so a stuck-low line cannot retrigger
          baud_cnt <= '0;
          if (rxd_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spart_key_rx.sv
// Bench for spart_key_rx: directed frames followed by random frames; expected
// strobes are queued by the stimulus and matched by an independent monitor.
module tb_spart_key_rx;

  localparam int D = 16;
  // Cycles from driving the start bit to the output strobe:
  // 2 (synchroniser) + D/2 (start) + 9*D (data + stop) + 1 (registered output)
  localparam int LAT = 2 + D / 2 + 9 * D + 1;

  logic        clk;
  logic        rst_n;
  logic        rxd;
  logic        SPART_we;
  logic [12:0] SPART_keys;
  logic [7:0]  rx_data;
  logic        rx_err;
  logic        rx_busy;

  typedef struct {
    bit          is_err;
    logic [12:0] keys;
    int          cyc;
  } ev_t;

  ev_t         q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [7:0]  exp_rx_data = 8'h00;
  logic        prev_we;
  logic [12:0] prev_keys;
  string       keymap = "wsadqeikjluo ";

  spart_key_rx #(.BAUD_DIV(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .rx_data    (rx_data),
    .rx_err     (rx_err),
    .rx_busy    (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference decode: which key (if any) a received byte should produce
  function automatic void model(input logic [7:0] b, output bit strobe, output logic [12:0] keys);
    logic [7:0] c;
    c = b;
    if (b >= 8'h41 && b <= 8'h5A) c = b + 8'd32;
    strobe = 1'b0;
    keys   = 13'h0000;
    if (b == 8'h1B) strobe = 1'b1;
    for (int i = 0; i < keymap.len(); i++) begin
      if (keymap[i] == c) begin
        strobe = 1'b1;
        keys   = 13'h0001 << i;
      end
    end
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; entered and left at 1 time unit after a rising edge
  task automatic send_frame(input logic [7:0] b, input logic stop);
    bit          strobe;
    logic [12:0] keys;
    ev_t         e;
    model(b, strobe, keys);
    if (!stop) begin
      e.is_err = 1'b1; e.keys = 13'h0; e.cyc = cyc + LAT;
      q.push_back(e);
    end else begin
      exp_rx_data = b;
      if (strobe) begin
        e.is_err = 1'b0; e.keys = keys; e.cyc = cyc + LAT;
        q.push_back(e);
      end
    end
    $display("frame byte=%02h stop=%0b strobe=%0b keys=%04h", b, stop, strobe && stop, keys);
    rxd = 1'b0;
    idle(D);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(D);
    end
    rxd = stop;
    idle(D);
    chk("rx_data_after_frame", {24'h0, rx_data}, {24'h0, exp_rx_data});
    chk("rx_busy_after_frame", {31'h0, rx_busy}, {31'h0, ~stop});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   {31'h0, SPART_we},   32'h0);
    chk({tag, "_keys"}, {19'h0, SPART_keys}, 32'h0);
    chk({tag, "_data"}, {24'h0, rx_data},    32'h0);
    chk({tag, "_err"},  {31'h0, rx_err},     32'h0);
    chk({tag, "_busy"}, {31'h0, rx_busy},    32'h0);
  endtask

  // Monitor: pops one expected event per output strobe and checks invariants
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we   = 1'b0;
      prev_keys = 13'h0;
    end else begin
      if (SPART_we || rx_err) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe we=%0b err=%0b keys=%04h cyc=%0d", SPART_we, rx_err, SPART_keys, cyc);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("strobe_kind_we", {31'h0, SPART_we}, {31'h0, ~e.is_err});
          chk("strobe_kind_err", {31'h0, rx_err}, {31'h0, e.is_err});
          if (!e.is_err) chk("strobe_keys", {19'h0, SPART_keys}, {19'h0, e.keys});
          chk("strobe_cycle", cyc, e.cyc);
          $display("strobe we=%0b err=%0b keys=%04h cyc=%0d", SPART_we, rx_err, SPART_keys, cyc);
        end
      end
      if (SPART_we && prev_we) chk("we_back_to_back", 32'd1, 32'd0);
      if (!SPART_we && SPART_keys !== prev_keys)
        chk("keys_changed_without_we", {19'h0, SPART_keys}, {19'h0, prev_keys});
      prev_we   = SPART_we;
      prev_keys = SPART_keys;
    end
  end

  initial begin
    logic [7:0] b;
    int         sel;
    int         c;
    rst_n = 1'b0;
    rxd   = 1'b1;
    idle(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(5);

    // Single mapped key
    send_frame(8'h77, 1'b1);
    // Uppercase fold then space, back to back
    send_frame(8'h44, 1'b1);
    send_frame(8'h20, 1'b1);
    // Unmapped character, then key release
    send_frame(8'h23, 1'b1);
    send_frame(8'h1B, 1'b1);

    // Framing error with the line held low afterwards
    send_frame(8'h61, 1'b0);
    idle(40);
    chk("break_busy_held", {31'h0, rx_busy}, 32'd1);
    chk("break_rx_data", {24'h0, rx_data}, {24'h0, exp_rx_data});
    rxd = 1'b1;
    idle(5);
    chk("break_release_busy", {31'h0, rx_busy}, 32'd0);
    send_frame(8'h61, 1'b1);

    // Short glitch on an idle line
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    chk("glitch_busy_high", {31'h0, rx_busy}, 32'd1);
    idle(20);
    chk("glitch_busy_low", {31'h0, rx_busy}, 32'd0);
    $display("glitch done");

    // Reset during data bit 4 of a 'k' frame
    b = 8'h6B;
    rxd = 1'b0;
    idle(D);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      idle(D);
    end
    rxd = b[4];
    idle(D / 2);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    rxd = 1'b1;
    idle(3);
    rst_n = 1'b1;
    exp_rx_data = 8'h00;
    idle(5);
    chk("post_reset_data", {24'h0, rx_data}, 32'h0);
    $display("mid-frame reset done");
    send_frame(8'h6B, 1'b1);

    // Randomised frames with random inter-frame gaps
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      c   = $urandom_range(0, keymap.len() - 1);
      case (sel)
        0: b = keymap[c];
        1: b = (keymap[c] == 8'h20) ? 8'h20 : keymap[c] - 8'd32;
        2: b = 8'h1B;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, 1'b1);
      idle($urandom_range(0, 3));
    end

    idle(20);
    chk("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
